// File: rtl/door_limit_model.sv
// door_limit_model: door/plant emulator closing the loop around a motor controller.
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   Up_Motor   in   drive toward TRAVEL_MAX
//   Down_Motor in   drive toward 0
//   Obstruct   in   freezes motion while high
//   Up_Max     out  registered, Position == TRAVEL_MAX
//   Down_Max   out  registered, Position == 0
//   Position   out  registered door position
//   Moving     out  rising/falling and not obstructed
//   Fault      out  registered, both motors were commanded together
module door_limit_model #(
  parameter int POS_W          = 8,
  parameter int TRAVEL_MAX     = 200,
  parameter int STEP_DIV       = 4,
  parameter int INIT_AT_BOTTOM = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Up_Motor,
  input  logic             Down_Motor,
  input  logic             Obstruct,
  output logic             Up_Max,
  output logic             Down_Max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault
);
  localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [POS_W-1:0] TOP = POS_W'(TRAVEL_MAX);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
  typedef enum logic [2:0] {AT_BOTTOM, RISING, AT_TOP, FALLING, MID_STOP, FAULT} state_t;
  state_t state, state_n, rest;
  logic [POS_W-1:0] pos_n;
  logic [CW-1:0] cnt, cnt_n;
  logic wrap;
  assign Moving = (state == RISING || state == FALLING) && !Obstruct;
  assign wrap = cnt == LAST;
  always_comb begin
    state_n = state;
    pos_n = Position;
    cnt_n = cnt;
    // every stop resolves to the state implied by where the door actually is
    rest = Position == '0 ? AT_BOTTOM : Position == TOP ? AT_TOP : MID_STOP;
    if (Up_Motor && Down_Motor) begin
      state_n = FAULT;
      cnt_n = '0;
    end else if (state == FAULT) begin
      if (!Up_Motor && !Down_Motor) state_n = rest;
    end else if (!Obstruct) begin
      case (state)
        AT_BOTTOM, AT_TOP, MID_STOP: begin
          state_n = Up_Motor && Position != TOP ? RISING :
                    Down_Motor && Position != '0 ? FALLING : state;
          cnt_n = '0;
        end
        RISING: begin
          // end-stop step completes regardless of the motor command
          if (wrap && Position >= TOP - POS_W'(1)) begin
            pos_n = TOP;
            state_n = AT_TOP;
            cnt_n = '0;
          end else if (Up_Motor) begin
            cnt_n = wrap ? '0 : cnt + CW'(1);
            pos_n = wrap ? Position + POS_W'(1) : Position;
          end else begin
            state_n = Down_Motor ? FALLING : rest;
            cnt_n = '0;
          end
        end
        FALLING: begin
          if (wrap && Position <= POS_W'(1)) begin
            pos_n = '0;
            state_n = AT_BOTTOM;
            cnt_n = '0;
          end else if (Down_Motor) begin
            cnt_n = wrap ? '0 : cnt + CW'(1);
            pos_n = wrap ? Position - POS_W'(1) : Position;
          end else begin
            state_n = Up_Motor ? RISING : rest;
            cnt_n = '0;
          end
        end
        default: state_n = rest;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= INIT_AT_BOTTOM != 0 ? AT_BOTTOM : AT_TOP;
      Position <= INIT_AT_BOTTOM != 0 ? '0 : TOP;
      Down_Max <= INIT_AT_BOTTOM != 0;
      Up_Max <= INIT_AT_BOTTOM == 0;
      Fault <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      Position <= pos_n;
      Down_Max <= pos_n == '0;
      Up_Max <= pos_n == TOP;
      Fault <= state_n == FAULT;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_door_limit_model.sv
// tb_door_limit_model: vector table, hand sequences and random run against a direction/progress model.
module tb_door_limit_model;
  localparam int TM = 10;
  localparam int SD = 2;
  logic CLK = 0, RST = 0, up = 0, dn = 0, obs = 0;
  logic Up_Max, Down_Max, Moving, Fault;
  logic [7:0] Position;
  int n_chk = 0, n_pass = 0;
  int m_pos, m_dir, m_prog;
  bit m_fault;
  typedef struct {bit u, d, o; int pos; bit um, dm, f, mv;} vec_t;
  vec_t tbl[17];

  door_limit_model #(.POS_W(8), .TRAVEL_MAX(TM), .STEP_DIV(SD), .INIT_AT_BOTTOM(1)) dut (
    .CLK(CLK), .RST(RST), .Up_Motor(up), .Down_Motor(dn), .Obstruct(obs),
    .Up_Max(Up_Max), .Down_Max(Down_Max), .Position(Position), .Moving(Moving), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    m_pos = 0; m_dir = 0; m_prog = 0; m_fault = 0;
  endtask

  // direction (+1/-1/0) plus progress-within-unit view of the door
  task automatic model_step(bit u, bit d, bit o);
    int want;
    want = u ? 1 : (d ? -1 : 0);
    if (u && d) begin
      m_fault = 1; m_dir = 0; m_prog = 0;
    end else if (m_fault) begin
      if (!u && !d) m_fault = 0;
    end else if (!o) begin
      if (m_dir == 0) begin
        if ((want > 0 && m_pos < TM) || (want < 0 && m_pos > 0)) begin
          m_dir = want; m_prog = 0;
        end
      end else if (m_prog == SD - 1 && (m_dir > 0 ? m_pos >= TM - 1 : m_pos <= 1)) begin
        m_pos = m_dir > 0 ? TM : 0; m_dir = 0; m_prog = 0;
      end else if (want == m_dir) begin
        m_prog++;
        if (m_prog == SD) begin
          m_prog = 0; m_pos += m_dir;
        end
      end else begin
        m_dir = want; m_prog = 0;
      end
    end
  endtask

  task automatic cmp_model(string tag);
    chk({tag, " pos"}, int'(Position), m_pos);
    chk({tag, " up_max"}, int'(Up_Max), int'(m_pos == TM));
    chk({tag, " down_max"}, int'(Down_Max), int'(m_pos == 0));
    chk({tag, " fault"}, int'(Fault), int'(m_fault));
    chk({tag, " moving"}, int'(Moving), int'(m_dir != 0 && !obs));
  endtask

  task automatic step(bit u, bit d, bit o, string tag);
    up = u; dn = d; obs = o;
    @(posedge CLK);
    model_step(u, d, o);
    @(negedge CLK);
    cmp_model(tag);
  endtask

  task automatic do_reset();
    up = 0; dn = 0; obs = 0; RST = 0;
    model_reset();
    @(negedge CLK);
    chk("reset pos", int'(Position), 0);
    chk("reset down_max", int'(Down_Max), 1);
    chk("reset up_max", int'(Up_Max), 0);
    chk("reset fault", int'(Fault), 0);
    chk("reset moving", int'(Moving), 0);
    RST = 1;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 1};
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 0, 1};
    tbl[2]  = '{1, 0, 0, 1, 0, 0, 0, 1};
    tbl[3]  = '{1, 0, 0, 1, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 0, 0, 0, 1};
    tbl[6]  = '{0, 1, 0, 1, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 0, 1, 1, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0};
    tbl[12] = '{1, 0, 1, 0, 0, 1, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 1, 0, 1};
    tbl[14] = '{1, 0, 1, 0, 0, 1, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 1, 0, 1};
    tbl[16] = '{1, 0, 0, 1, 0, 0, 0, 1};
    @(negedge CLK);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      up = tbl[i].u; dn = tbl[i].d; obs = tbl[i].o;
      @(posedge CLK);
      model_step(tbl[i].u, tbl[i].d, tbl[i].o);
      @(negedge CLK);
      chk($sformatf("vec%0d pos", i), int'(Position), tbl[i].pos);
      chk($sformatf("vec%0d up_max", i), int'(Up_Max), int'(tbl[i].um));
      chk($sformatf("vec%0d down_max", i), int'(Down_Max), int'(tbl[i].dm));
      chk($sformatf("vec%0d fault", i), int'(Fault), int'(tbl[i].f));
      chk($sformatf("vec%0d moving", i), int'(Moving), int'(tbl[i].mv));
    end
    do_reset();
    for (int i = 0; i < 25; i++) begin
      step(1, 0, 0, "rise");
      if (i == 2) chk("first step down_max", int'(Down_Max), 0);
    end
    chk("top pos", int'(Position), TM);
    chk("top up_max", int'(Up_Max), 1);
    for (int i = 0; i < 21; i++) step(0, 1, 0, "fall");
    chk("bottom pos", int'(Position), 0);
    chk("bottom down_max", int'(Down_Max), 1);
    chk("bottom up_max", int'(Up_Max), 0);
    for (int i = 0; i < 13; i++) step(1, 0, 0, "rise6");
    chk("pos6", int'(Position), 6);
    for (int i = 0; i < 5; i++) step(1, 0, 1, "obstruct");
    chk("obstruct pos", int'(Position), 6);
    chk("obstruct moving", int'(Moving), 0);
    step(1, 1, 0, "both");
    chk("fault set", int'(Fault), 1);
    chk("fault pos", int'(Position), 6);
    step(0, 0, 0, "fault exit");
    chk("fault cleared", int'(Fault), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, "mid stop");
    chk("mid stop pos", int'(Position), 6);
    step(1, 0, 0, "resume");
    step(1, 0, 0, "resume");
    chk("resume no step yet", int'(Position), 6);
    step(1, 0, 0, "resume");
    chk("resume step", int'(Position), 7);
    #3 RST = 0;
    #1;
    chk("async pos", int'(Position), 0);
    chk("async down_max", int'(Down_Max), 1);
    chk("async fault", int'(Fault), 0);
    model_reset();
    @(negedge CLK);
    RST = 1;
    begin
      bit cu, cd;
      int r;
      cu = 0; cd = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(7) == 0) begin
          r = $urandom_range(15);
          cu = (r >= 5 && r < 10) || r == 15;
          cd = (r >= 10);
        end
        step(cu, cd, $urandom_range(9) == 0, "rand");
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
